// File: rtl/i2c_passthru_dir_ctrl.sv
// Direction controller for a multi-channel I2C pass-through: tracks the bus
// transaction bit by bit and decides, per bit, whether data flows master->slave or slave->master.
module i2c_passthru_dir_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int CH_IDX_W    = 1,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int BYTE_CNT_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_CH-1:0]     i_scl,
    input  logic [NUM_CH-1:0]     i_sda,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic                  i_rx_sda_init_valid,
    input  logic                  i_rx_sda_init,
    input  logic                  i_tx_slv_on_mst_ch,
    output logic                  o_start,
    output logic                  o_tx_to_mst,
    output logic [CH_IDX_W-1:0]   o_mst_ch,
    output logic                  o_busy,
    output logic                  o_ack_failed,
    output logic                  o_timeout,
    output logic [BYTE_CNT_W-1:0] o_byte_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MST_WAIT  = 3'd1,
        ST_MST_START = 3'd2,
        ST_SLV_WAIT  = 3'd3,
        ST_SLV_START = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0]  TIMEOUT_LIM = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_MAX    = {BYTE_CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [NUM_CH-1:0]      prev_sda_q, prev_sda_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   first_byte_n_q, first_byte_n_d;
    logic                   read_mode_q, read_mode_d;
    logic                   read_mode_early_q, read_mode_early_d;
    logic                   ack_failed_q, ack_failed_d;
    logic                   slv_on_mst_side_q, slv_on_mst_side_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   timeout_q, timeout_d;
    logic [CH_IDX_W-1:0]    mst_ch_q, mst_ch_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;

    logic [NUM_CH-1:0]      start_vec_s;
    logic [NUM_CH-1:0]      stop_vec_s;
    logic                   start_any_s;
    logic                   stop_own_s;
    logic [CH_IDX_W-1:0]    start_ch_s;
    logic                   start_pulse_s;
    logic                   busy_s;
    logic                   wait_st_s;
    logic                   timer_hit_s;
    logic                   rx_from_slv_s;

    // START/STOP detection per channel and lowest-index START arbitration
    always_comb begin
        start_vec_s = i_scl & prev_sda_q & ~i_sda;
        stop_vec_s  = i_scl & ~prev_sda_q & i_sda;
        start_any_s = |start_vec_s;
        start_ch_s  = {CH_IDX_W{1'b0}};
        stop_own_s  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            start_ch_s = start_vec_s[k] ? CH_IDX_W'(k) : start_ch_s;
            stop_own_s = stop_own_s | (stop_vec_s[k] & (CH_IDX_W'(k) == mst_ch_q));
        end
    end

    // State decode and direction decision for the next bit
    always_comb begin
        start_pulse_s = (state_q == ST_MST_START) || (state_q == ST_SLV_START);
        busy_s        = (state_q != ST_IDLE);
        wait_st_s     = (state_q == ST_MST_WAIT) || (state_q == ST_SLV_WAIT);
        timer_hit_s   = wait_st_s && (timer_q == TIMEOUT_LIM);
        // the ACK slot after bit 8 reverses the data direction
        rx_from_slv_s = ~slv_on_mst_side_q & ~ack_failed_q &
                        ((bit_cnt_q == 4'd8) ? ~read_mode_q : read_mode_q);
    end

    // Next-state, bit tracking and stall timer
    always_comb begin
        state_d           = state_q;
        prev_sda_d        = i_sda;
        bit_cnt_d         = bit_cnt_q;
        first_byte_n_d    = first_byte_n_q;
        read_mode_d       = read_mode_q;
        read_mode_early_d = read_mode_early_q;
        ack_failed_d      = ack_failed_q;
        slv_on_mst_side_d = slv_on_mst_side_q | (busy_s & i_tx_slv_on_mst_ch);
        byte_cnt_d        = byte_cnt_q;
        timeout_d         = timeout_q;
        mst_ch_d          = mst_ch_q;
        timer_d           = timer_q;

        if (start_pulse_s) begin
            bit_cnt_d   = (bit_cnt_q == 4'd9) ? 4'd1 : (bit_cnt_q + 4'd1);
            read_mode_d = read_mode_early_q;
            if ((bit_cnt_q == 4'd9) && (byte_cnt_q != BYTE_MAX)) begin
                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end else begin
                byte_cnt_d = byte_cnt_q;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (busy_s && (bit_cnt_q == 4'd9)) begin
            first_byte_n_d = 1'b1;
        end else begin
            first_byte_n_d = first_byte_n_q;
        end

        // R/W bit of the address byte is bit 8 of the first byte
        if (busy_s && (bit_cnt_q == 4'd8) && !first_byte_n_q && i_rx_sda_init_valid) begin
            read_mode_early_d = i_rx_sda_init;
        end else begin
            read_mode_early_d = read_mode_early_q;
        end

        if (busy_s && (bit_cnt_q == 4'd9) && i_rx_sda_init_valid && !ack_failed_q) begin
            ack_failed_d = i_rx_sda_init;
        end else begin
            ack_failed_d = ack_failed_q;
        end

        if (start_any_s) begin
            state_d           = ST_MST_WAIT;
            bit_cnt_d         = 4'd0;
            first_byte_n_d    = 1'b0;
            read_mode_d       = 1'b0;
            read_mode_early_d = 1'b0;
            ack_failed_d      = 1'b0;
            slv_on_mst_side_d = 1'b0;
            byte_cnt_d        = {BYTE_CNT_W{1'b0}};
            timeout_d         = 1'b0;
            mst_ch_d          = start_ch_s;
            timer_d           = {TIMEOUT_W{1'b0}};
        end else if (busy_s && stop_own_s) begin
            state_d = ST_IDLE;
            timer_d = {TIMEOUT_W{1'b0}};
        end else if (timer_hit_s) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            timer_d   = {TIMEOUT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = {TIMEOUT_W{1'b0}};
                end
                ST_MST_WAIT, ST_SLV_WAIT: begin
                    if (i_rx_done && i_tx_done) begin
                        state_d = rx_from_slv_s ? ST_SLV_START : ST_MST_START;
                        timer_d = {TIMEOUT_W{1'b0}};
                    end else begin
                        timer_d = timer_q + TIMEOUT_W'(1);
                    end
                end
                ST_MST_START: begin
                    state_d = ST_MST_WAIT;
                    timer_d = {TIMEOUT_W{1'b0}};
                end
                ST_SLV_START: begin
                    state_d = ST_SLV_WAIT;
                    timer_d = {TIMEOUT_W{1'b0}};
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = {TIMEOUT_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= ST_IDLE;
            prev_sda_q        <= {NUM_CH{1'b1}};
            bit_cnt_q         <= 4'd0;
            first_byte_n_q    <= 1'b0;
            read_mode_q       <= 1'b0;
            read_mode_early_q <= 1'b0;
            ack_failed_q      <= 1'b0;
            slv_on_mst_side_q <= 1'b0;
            byte_cnt_q        <= {BYTE_CNT_W{1'b0}};
            timeout_q         <= 1'b0;
            mst_ch_q          <= {CH_IDX_W{1'b0}};
            timer_q           <= {TIMEOUT_W{1'b0}};
        end else begin
            state_q           <= state_d;
            prev_sda_q        <= prev_sda_d;
            bit_cnt_q         <= bit_cnt_d;
            first_byte_n_q    <= first_byte_n_d;
            read_mode_q       <= read_mode_d;
            read_mode_early_q <= read_mode_early_d;
            ack_failed_q      <= ack_failed_d;
            slv_on_mst_side_q <= slv_on_mst_side_d;
            byte_cnt_q        <= byte_cnt_d;
            timeout_q         <= timeout_d;
            mst_ch_q          <= mst_ch_d;
            timer_q           <= timer_d;
        end
    end

    assign o_start      = start_pulse_s;
    assign o_tx_to_mst  = (state_q == ST_SLV_START) || (state_q == ST_SLV_WAIT);
    assign o_mst_ch     = mst_ch_q;
    assign o_busy       = busy_s;
    assign o_ack_failed = ack_failed_q;
    assign o_timeout    = timeout_q;
    assign o_byte_cnt   = byte_cnt_q;

endmodule
